uart_rx_ctl: RTL

//  Parametrised UART receive controller: rxd -> synchroniser -> 16x-oversampled frame FSM -> RX FIFO -> host.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/uart_rx_ctl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and bit-timing constants for the UART receive path.
// Bit timing assumes a 16x oversampling enable.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK
   } rx_state_e;

   localparam int         OVS        = 16;
   localparam int         TICK_W     = $clog2(OVS);
   localparam logic [3:0] MID_SAMPLE = 4'd7;
   localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX word FIFO: dout/empty/level register one clk after push/pop.
// Push into a full FIFO without a same-clk pop is dropped; push+pop when full both succeed.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              do_push, do_pop;

   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      dout_d  = dout_q;
      // A word written this clk becomes the head only when it is the sole entry left.
      if (cnt_d != '0) begin
         if (do_push && (cnt_d == CW'(1)))
            dout_d = din;
         else
            dout_d = mem_q[rd_d];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_q] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign level = cnt_q;

endmodule

// File: rtl/uart_rx_ctl.sv
// UART receiver: rxd sync -> 16x frame FSM -> FIFO; word pushed 1 clk after stop sample, visible 1 clk later.
// No backpressure on the line: full FIFO drops words (overrun); rts hysteresis asks the peer to pause. Parity via UART_RX_PARITY_EN.
module uart_rx_ctl
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int RTS_HI     = 12,
   parameter int RTS_LO     = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     baud_tick,
   input  logic                     rxd,
   input  logic                     rd,
   output logic [DATA_W-1:0]        dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     rts,
   output logic                     frame_err,
   output logic                     overrun,
   output logic                     parity_err
);

   localparam int LW  = $clog2(DEPTH) + 1;
   localparam int BCW = $clog2(DATA_W);

`ifdef UART_RX_PARITY_EN
   localparam rx_state_e AFTER_DATA = PARITY;
   localparam logic      PAR_ODD    = (PARITY_ODD != 0);
   logic par_bad_q;
   logic parity_err_q;
`else
   localparam rx_state_e AFTER_DATA = STOP;
`endif

   logic              sync1_q, sync2_q;
   logic              rxd_s;
   rx_state_e         state_q;
   logic [TICK_W-1:0] tick_q;
   logic [BCW-1:0]    bit_q;
   logic [DATA_W-1:0] shreg_q;
   logic              push_q;
   logic              frame_err_q;
   logic              overrun_q;
   logic              rts_q;
   logic              par_fail;
   logic              full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   assign rxd_s = sync2_q;

`ifdef UART_RX_PARITY_EN
   assign par_fail   = par_bad_q;
   assign parity_err = parity_err_q;
`else
   assign par_fail   = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         if (baud_tick) begin
            case (state_q)
               IDLE: begin
                  if (!rxd_s) begin
                     state_q <= START;
                     tick_q  <= '0;
                  end
               end
               START: begin
                  // A start bit that is high again at mid-bit was only a glitch.
                  if (tick_q == MID_SAMPLE) begin
                     if (rxd_s) begin
                        state_q <= IDLE;
                     end else begin
                        state_q <= DATA;
                        tick_q  <= '0;
                        bit_q   <= '0;
                     end
                  end else begin
                     tick_q <= tick_q + TICK_W'(1);
                  end
               end
               DATA: begin
                  tick_q <= tick_q + TICK_W'(1);
                  if (tick_q == LAST_TICK) begin
                     shreg_q <= {rxd_s, shreg_q[DATA_W-1:1]};
                     bit_q   <= bit_q + BCW'(1);
                     if (bit_q == BCW'(DATA_W - 1))
                        state_q <= AFTER_DATA;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  tick_q <= tick_q + TICK_W'(1);
                  if (tick_q == LAST_TICK) begin
                     par_bad_q <= (rxd_s != ((^shreg_q) ^ PAR_ODD));
                     state_q   <= STOP;
                  end
               end
`endif
               STOP: begin
                  tick_q <= tick_q + TICK_W'(1);
                  if (tick_q == LAST_TICK) begin
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= par_bad_q;
`endif
                     if (rxd_s) begin
                        push_q  <= !par_fail;
                        state_q <= IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BRK;
                     end
                  end
               end
               BRK: begin
                  if (rxd_s)
                     state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   uart_rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .pop   (rd),
      .din   (shreg_q),
      .dout  (dout),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
         rts_q     <= 1'b0;
      end else begin
         overrun_q <= push_q && full && !rd;
         if (level >= LW'(RTS_HI))
            rts_q <= 1'b1;
         else if (level <= LW'(RTS_LO))
            rts_q <= 1'b0;
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rts       = rts_q;

endmodule
